// File: rtl/top_of_book_tx_pkg.sv
// Shared types and message geometry for the top-of-book quote transmitter.
// TOB_CHECKSUM_EN adds a trailing XOR checksum byte to every message.
package top_of_book_tx_pkg;

`ifdef TOB_CHECKSUM_EN
    localparam int unsigned TOB_MSG_BYTES = 24;
`else
    localparam int unsigned TOB_MSG_BYTES = 23;
`endif
    localparam int unsigned TOB_MSG_BITS  = TOB_MSG_BYTES * 8;
    localparam int unsigned TOB_IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } tob_state_t;

    // Field order matches wire order (big-endian, MSB first).
    typedef struct packed {
        logic [15:0] locate;
        logic [31:0] seq;
        logic [31:0] bid_px;
        logic [31:0] bid_qty;
        logic [31:0] ask_px;
        logic [31:0] ask_qty;
    } tob_quote_t;

    typedef struct packed {
        logic [15:0] locate;
        logic [31:0] bid_px;
        logic [31:0] bid_qty;
        logic [31:0] ask_px;
        logic [31:0] ask_qty;
    } tob_book_t;

`ifdef TOB_CHECKSUM_EN
    function automatic logic [7:0] tob_xor_bytes(input logic [TOB_MSG_BITS-9:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < int'(TOB_MSG_BYTES) - 1; i++) begin
            acc = acc ^ body[i*8 +: 8];
        end
        return acc;
    endfunction
`endif

endpackage

// File: rtl/tob_byte_serializer.sv
// Parallel-load shift register that streams a message MSB-first over valid/ready.
// Message length follows TOB_CHECKSUM_EN through the package.
module tob_byte_serializer
    import top_of_book_tx_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [TOB_MSG_BITS-1:0] load_data,
    input  logic                    ready,
    output logic [7:0]              data,
    output logic                    valid,
    output logic                    last,
    output logic                    done
);

    localparam logic [TOB_IDX_W-1:0] LAST_IDX = TOB_IDX_W'(TOB_MSG_BYTES - 1);

    logic [TOB_MSG_BITS-1:0] shift_q;
    logic [TOB_IDX_W-1:0]    idx_q;
    logic                    valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= load_data;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            if (idx_q == LAST_IDX) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= {shift_q[TOB_MSG_BITS-9:0], 8'h00};
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

    assign data  = shift_q[TOB_MSG_BITS-1 -: 8];
    assign valid = valid_q;
    assign last  = valid_q && (idx_q == LAST_IDX);
    assign done  = last && ready;

endmodule

// File: rtl/top_of_book_tx.sv
// Top-of-book change detector and quote publisher; coalesces bursts to the latest quote.
// TOB_CHECKSUM_EN appends an XOR checksum byte (24-byte messages instead of 23).
module top_of_book_tx
    import top_of_book_tx_pkg::*;
#(
    parameter logic [7:0]  MSG_TYPE = 8'h51,
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        bookValidIn,
    input  logic [15:0] locateIn,
    input  logic [31:0] bidPriceIn,
    input  logic [31:0] bidQtyIn,
    input  logic [31:0] askPriceIn,
    input  logic [31:0] askQtyIn,
    output logic [7:0]  txDataOut,
    output logic        txValidOut,
    output logic        txLastOut,
    input  logic        txReadyIn,
    output logic [15:0] coalescedCntOut
);

    // IDLE and LOAD already provide two idle bus cycles after a final byte.
    localparam logic [7:0] GAP_RELOAD = (IDLE_GAP > 2) ? 8'(IDLE_GAP - 2) : 8'd0;

    tob_state_t state_q, state_d;
    tob_book_t  snapshot_q, snapshot_d;
    tob_book_t  last_sent_q, last_sent_d;
    tob_book_t  in_book;
    tob_book_t  cmp_ref;
    tob_quote_t quote;
    logic       pending_q, pending_d;
    logic [31:0] seq_q, seq_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] cnt_q, cnt_d;
    logic        load;
    logic        ser_done;
    logic [TOB_MSG_BITS-1:0] load_data;
    logic [TOB_MSG_BITS-1:0] body;

    assign in_book = '{locate: locateIn, bid_px: bidPriceIn, bid_qty: bidQtyIn,
                       ask_px: askPriceIn, ask_qty: askQtyIn};

    // A LOAD in progress makes the snapshot the new reference for change detection.
    assign cmp_ref = (state_q == LOAD) ? snapshot_q : last_sent_q;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q     <= IDLE;
            snapshot_q  <= '0;
            last_sent_q <= '0;
            pending_q   <= 1'b0;
            seq_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            seq_q       <= seq_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;
        seq_d       = seq_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (pending_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load        = 1'b1;
                last_sent_d = snapshot_q;
                seq_d       = seq_q + 32'd1;
                pending_d   = 1'b0;
                state_d     = SEND;
            end
            SEND: begin
                if (ser_done) begin
                    gap_d   = GAP_RELOAD;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bookValidIn) begin
            snapshot_d = in_book;
            pending_d  = (in_book != cmp_ref);
            if (pending_q && (state_q != LOAD) && (in_book != last_sent_q)
                && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign quote = '{locate: snapshot_q.locate, seq: seq_q + 32'd1,
                     bid_px: snapshot_q.bid_px, bid_qty: snapshot_q.bid_qty,
                     ask_px: snapshot_q.ask_px, ask_qty: snapshot_q.ask_qty};

`ifdef TOB_CHECKSUM_EN
    assign body      = {MSG_TYPE, quote, 8'h00};
    assign load_data = {body[TOB_MSG_BITS-1:8], tob_xor_bytes(body[TOB_MSG_BITS-1:8])};
`else
    assign body      = {MSG_TYPE, quote};
    assign load_data = body;
`endif

    tob_byte_serializer u_ser (
        .clk       (clkIn),
        .rst       (rstIn),
        .load      (load),
        .load_data (load_data),
        .ready     (txReadyIn),
        .data      (txDataOut),
        .valid     (txValidOut),
        .last      (txLastOut),
        .done      (ser_done)
    );

    assign coalescedCntOut = cnt_q;

endmodule
